// File: rtl/my_float_to_fixed_pkg.sv
// Shared definitions for the float32 -> fixed-point converter and other
// float units: float32 field layout, bias/offset constants, saturation
// values and the operand class enum.
package my_float_to_fixed_pkg;

  localparam int FLT_W      = 32;
  localparam int EXP_W      = 8;
  localparam int FRAC_FLD_W = 23;
  localparam int MANT_W     = FRAC_FLD_W + 1;  // with hidden bit
  localparam int SIGN_POS   = 31;
  localparam int EXP_LSB    = 23;
  localparam int EXP_BIAS   = 127;
  // Unbiasing plus moving the binary point to the mantissa LSB.
  localparam int SHIFT_OFS  = EXP_BIAS + FRAC_FLD_W;  // 150

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

  typedef enum logic [1:0] {NORM, ZERO, INF, NAN} fcls_t;

endpackage

// File: rtl/my_float_to_fixed_float_field_split.sv
// float_field_split: combinational float32 unpack.
//   f   : float32 operand
//   s   : sign
//   e   : biased exponent
//   m   : mantissa with hidden bit; zero for zero/denormal (flush to zero)
//   cls : NORM / ZERO / INF / NAN
module float_field_split
  import my_float_to_fixed_pkg::*;
(
  input  logic [FLT_W-1:0]  f,
  output logic              s,
  output logic [EXP_W-1:0]  e,
  output logic [MANT_W-1:0] m,
  output fcls_t             cls
);

  logic [FRAC_FLD_W-1:0] frac;

  always_comb begin
    s    = f[SIGN_POS];
    e    = f[EXP_LSB +: EXP_W];
    frac = f[FRAC_FLD_W-1:0];
    m    = (e != '0) ? {1'b1, frac} : '0;
    if (e == EXP_MAX)  cls = (frac != '0) ? NAN : INF;
    else if (e == '0)  cls = ZERO;
    else               cls = NORM;
  end

endmodule

// File: rtl/my_float_to_fixed.sv
// my_float_to_fixed: 3-stage float32 -> signed Q(31-fracBits).fracBits
// converter with saturation and a per-run saturation event counter.
//   clk, rst  : clock, async active-high reset
//   run       : start pulse; loads delay counter, clears out1
//   running   : pipeline advance enable
//   fracBits  : fractional output bits (static during a run)
//   in0       : float32 input
//   delay0    : leading running cycles excluded from counting
//   out0      : fixed-point result (latency 3)
//   out1      : saturation count, sticks at 0xFFFF
// Build option: MY_FLOAT_TO_FIXED_RNE_EN selects round-half-even on right
// shifts; otherwise right shifts truncate toward zero.
module my_float_to_fixed
  import my_float_to_fixed_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 7,
  parameter int FRAC_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               running,
  input  logic [FRAC_W-1:0]  fracBits,
  input  logic [DATA_W-1:0]  in0,
  input  logic [DELAY_W-1:0] delay0,
  output logic [31:0]        out0,
  output logic [15:0]        out1
);

  logic [31:0] dcnt;
  logic        vld_in;
  logic [1:0]  vld_pipe;

  // unpack
  logic              u_s;
  logic [EXP_W-1:0]  u_e;
  logic [MANT_W-1:0] u_m;
  fcls_t             u_cls;
  logic signed [9:0] sh_c;

  float_field_split u_split (
    .f  (in0),
    .s  (u_s),
    .e  (u_e),
    .m  (u_m),
    .cls(u_cls)
  );

  assign vld_in = running && (dcnt == '0);
  assign sh_c   = {2'b00, u_e} - 10'(SHIFT_OFS) + 10'(fracBits);

  // stage 1 regs
  logic              s1_s;
  logic [MANT_W-1:0] s1_m;
  fcls_t             s1_cls;
  logic signed [9:0] s1_sh;

  // stage 2 comb
  logic signed [9:0] nsh;
  logic [4:0]        rs;
  logic [31:0]       mag_r, mag_l, mag_c;
  logic              ovf_c;
`ifdef MY_FLOAT_TO_FIXED_RNE_EN
  logic [63:0]       wide;
  logic              rnd_up;
`endif

  always_comb begin
    nsh = -s1_sh;
    rs  = (nsh > 10'sd31) ? 5'd31 : nsh[4:0];
`ifdef MY_FLOAT_TO_FIXED_RNE_EN
    // Low word collects the shifted-out bits: [31] guard, [30:0] sticky.
    wide   = {8'b0, s1_m, 32'b0} >> rs;
    rnd_up = wide[31] & ((|wide[30:0]) | wide[32]);
    mag_r  = wide[63:32] + {31'b0, rnd_up};
`else
    mag_r  = {8'b0, s1_m} >> rs;
`endif
    // sh == 8 stays on the shift path so that exactly -2^31 survives.
    mag_l = {8'b0, s1_m} << s1_sh[3:0];
    if (s1_sh < 0)             mag_c = mag_r;
    else if (s1_sh <= 10'sd8)  mag_c = mag_l;
    else                       mag_c = '0;
    ovf_c = ((s1_sh > 10'sd8) && (s1_m != '0)) ||
            (!s1_s && (mag_c > SAT_POS)) ||
            ( s1_s && (mag_c > SAT_NEG));
  end

  // stage 2 regs
  logic        s2_s, s2_ovf;
  fcls_t       s2_cls;
  logic [31:0] s2_mag;

  // stage 3 comb
  logic        s2_sat;
  logic [31:0] out_c;

  always_comb begin
    s2_sat = (s2_cls == INF) || ((s2_cls != NAN) && s2_ovf);
    if (s2_cls == NAN)  out_c = '0;
    else if (s2_sat)    out_c = s2_s ? SAT_NEG : SAT_POS;
    else                out_c = s2_s ? -s2_mag : s2_mag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt     <= '0;
      vld_pipe <= '0;
      s1_s     <= 1'b0;
      s1_m     <= '0;
      s1_cls   <= NORM;
      s1_sh    <= '0;
      s2_s     <= 1'b0;
      s2_ovf   <= 1'b0;
      s2_cls   <= NORM;
      s2_mag   <= '0;
      out0     <= '0;
      out1     <= '0;
    end else begin
      if (run)                          dcnt <= {{(32-DELAY_W){1'b0}}, delay0};
      else if (running && dcnt != '0)   dcnt <= dcnt - 1'b1;

      if (running) begin
        vld_pipe <= {vld_pipe[0], vld_in};
        s1_s     <= u_s;
        s1_m     <= u_m;
        s1_cls   <= u_cls;
        s1_sh    <= sh_c;
        s2_s     <= s1_s;
        s2_ovf   <= ovf_c;
        s2_cls   <= s1_cls;
        s2_mag   <= mag_c;
        out0     <= out_c;
      end

      // run clears even if a saturated sample lands this cycle
      if (run)
        out1 <= '0;
      else if (running && vld_pipe[1] && s2_sat && out1 != 16'hFFFF)
        out1 <= out1 + 1'b1;
    end
  end

endmodule
